// File: rtl/fir_serial_pkg.sv
// Shared constants and helpers for the serial FIR filter and its MAC unit.
package fir_serial_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MAC  = 1'b1;

  // Ceiling log2 for deriving counter and accumulator widths at elaboration.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Combinational multiply-accumulate: sum = (first ? 0 : acc) + x*c, exact in ACC_W bits.
module fir_mac_unit #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] c,
  input  logic signed [ACC_W-1:0]  acc,
  input  logic                     first,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]         prod_ext;

  assign prod     = x * c;
  assign prod_ext = ACC_W'(prod);
  assign sum      = (first ? '0 : acc) + prod_ext;

endmodule

// File: rtl/fir_serial_param.sv
// Fully-serial direct-form FIR: one shared MAC stepped over TAPS taps per accepted sample.
module fir_serial_param
  import fir_serial_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  localparam int CNT_W = clog2(TAPS),
  localparam int ACC_W = DATA_W + COEF_W + clog2(TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              coef_we,
  input  logic [CNT_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid
);

  logic [0:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] x_dl [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [DATA_W-1:0] x_sel;
  logic signed [COEF_W-1:0] c_sel;
  logic signed [ACC_W-1:0]  mac_sum;

  assign in_ready = (state == IDLE);

  // Tap select mux; indices outside 0..TAPS-1 never match and read as zero.
  always_comb begin
    // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
    x_sel = '0;
    c_sel = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (cnt == CNT_W'(i)) begin
        x_sel = x_dl[i];
        c_sel = coef[i];
      end
    end
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .x     (x_sel),
    .c     (c_sel),
    .acc   (acc),
    .first (cnt == '0),
    .sum   (mac_sum)
  );

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      // NOTE: delay line and coefficient bank are architecturally cleared, so these
      // arrays are built from resettable flops rather than RAM.
      for (int i = 0; i < TAPS; i++) begin
        x_dl[i] <= '0;
        coef[i] <= '0;
      end
    end else if (clk_enable) begin
      out_valid <= 1'b0;
      if (state == IDLE) begin
        // Out-of-range addresses match no entry and are dropped.
        if (coef_we) begin
          for (int i = 0; i < TAPS; i++) begin
            if (coef_addr == CNT_W'(i)) coef[i] <= coef_data;
          end
        end
        if (in_valid) begin
          x_dl[0] <= in_data;
          for (int i = TAPS - 1; i > 0; i--) x_dl[i] <= x_dl[i-1];
          cnt   <= '0;
          state <= MAC;
        end
      end else begin
        acc <= mac_sum;
        if (cnt == CNT_W'(TAPS - 1)) begin
          out_data  <= mac_sum;
          out_valid <= 1'b1;
          cnt       <= '0;
          state     <= IDLE;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_serial_param.sv
// Self-checking bench for fir_serial_param: vector table, directed corner cases, random vs model.
module tb_fir_serial_param;

  localparam int TAPS = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic [34:0] out_data;
  logic        out_valid;

  fir_serial_param dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .out_data   (out_data),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: history of accepted samples and the coefficient bank.
  int     mx [TAPS];
  int     mc [TAPS];
  longint exp_pending = 0;
  int     last_pulse = 0;
  int     prev_pulse = 0;

  typedef struct {
    int     din;
    longint expv;
  } vec_t;
  vec_t tbl [17];

  task automatic check(input string name, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint model_out();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(mx[k]) * longint'(mc[k]);
    return s;
  endfunction

  task automatic write_coef(input int a, input int v);
    coef_we   = 1'b1;
    coef_addr = 3'(a);
    coef_data = 16'(v);
    step();
    coef_we = 1'b0;
    mc[a] = v;
  endtask

  task automatic accept(input int d, input bit wr = 1'b0, input int wa = 0, input int wv = 0);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("ready_wait", longint'(in_ready), 1);
    in_data   = 16'(d);
    in_valid  = 1'b1;
    coef_we   = wr;
    coef_addr = 3'(wa);
    coef_data = 16'(wv);
    step();
    in_valid = 1'b0;
    coef_we  = 1'b0;
    if (wr) mc[wa] = wv;
    for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = d;
    exp_pending = model_out();
    check("busy_after_accept", longint'(in_ready), 0);
    check("pulse_one_cycle", longint'(out_valid), 0);
  endtask

  task automatic wait_out(input string name, output longint got, output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check({name, "_valid"}, longint'(out_valid), 1);
    got = longint'($signed(out_data));
    check({name, "_data"}, got, exp_pending);
    prev_pulse = last_pulse;
    last_pulse = cyc;
  endtask

  initial begin
    longint got;
    int     lat;
    int     seen;

    for (int i = 0; i < TAPS; i++) begin
      tbl[i].din  = (i == 0) ? 1 : 0;
      tbl[i].expv = i + 1;
    end
    for (int i = 0; i < 9; i++) begin
      tbl[8+i].din  = 1;
      tbl[8+i].expv = (i < 8) ? (i + 1) * (i + 2) / 2 : 36;
    end
    for (int i = 0; i < TAPS; i++) begin
      mx[i] = 0;
      mc[i] = 0;
    end

    // Reset state
    step();
    step();
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    reset = 1'b1;
    step();

    // Impulse then step response from the vector table
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    for (int i = 0; i < 17; i++) begin
      accept(tbl[i].din);
      wait_out($sformatf("vec%0d", i), got, lat);
      check($sformatf("vec%0d_table", i), got, tbl[i].expv);
      if (i == 0) check("latency", lat, TAPS);
      else check($sformatf("vec%0d_period", i), last_pulse - prev_pulse, TAPS + 1);
    end

    // Negative extremes: eighth output must be exactly 2^33
    for (int k = 0; k < TAPS; k++) write_coef(k, -32768);
    for (int i = 0; i < TAPS; i++) begin
      accept(-32768);
      wait_out($sformatf("neg%0d", i), got, lat);
    end
    check("neg_extreme", got, 64'sh2_0000_0000);

    // Coefficient write during MAC is ignored
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    accept(3);
    step();
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'd5;
    step();
    coef_we = 1'b0;
    wait_out("wr_mac", got, lat);
    accept(7);
    wait_out("wr_mac_after", got, lat);

    // Reset mid-MAC abandons the sample
    accept(1);
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_out_data", longint'(out_data), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    for (int i = 0; i < TAPS; i++) begin
      mx[i] = 0;
      mc[i] = 0;
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("midrst_no_pulse", seen, 0);
    accept(1);
    wait_out("post_rst_impulse", got, lat);
    check("post_rst_zero", got, 0);
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    accept(1);
    wait_out("post_rst_reload", got, lat);

    // clk_enable gating stretches latency and freezes out_valid
    accept(5);
    step();
    clk_enable = 1'b0;
    repeat (3) step();
    clk_enable = 1'b1;
    wait_out("gated", got, lat);
    check("gated_latency", 1 + 3 + lat, TAPS + 3);
    clk_enable = 1'b0;
    step();
    step();
    check("frozen_valid", longint'(out_valid), 1);
    clk_enable = 1'b1;
    step();
    check("valid_cleared", longint'(out_valid), 0);

    // Random samples and coefficients, some writes coincident with accept
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($signed(16'($urandom))));
    for (int i = 0; i < 24; i++) begin
      int d;
      d = int'($signed(16'($urandom)));
      if ($urandom_range(0, 3) == 0)
        accept(d, 1'b1, int'($urandom_range(0, TAPS - 1)), int'($signed(16'($urandom))));
      else
        accept(d);
      wait_out($sformatf("rnd%0d", i), got, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
